// File: rtl/prbs9_ber_ctrl.sv
// PRBS9 (x^9+x^5+1) bit-error-rate test controller: sequences the generator reset,
// self-synchronises a local predictor to the received stream, then counts bits and errors.
module prbs9_ber_ctrl #(
    parameter int CNT_W    = 16,
    parameter int ERR_W    = 16,
    parameter int LOCK_LEN = 9,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_n_bits,
    input  logic             i_rx_bit,
    input  logic             i_rx_valid,
    output logic             o_gen_rst_n,
    output logic             o_busy,
    output logic             o_locked,
    output logic             o_done,
    output logic             o_lock_fail,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [ERR_W-1:0] o_err_count,
    output logic [2:0]       o_state_dbg
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT);
    localparam logic [7:0]      LOCK_CNT = 8'(LOCK_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_COUNT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       s_q, s_d;
    logic [CNT_W-1:0] n_bits_q, n_bits_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [TO_W-1:0]  tout_q, tout_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;

    logic             p;
    logic [8:0]       s_rx;
    logic             lock_now;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            n_bits_q  <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            tout_q    <= '0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_bits_q  <= n_bits_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            tout_q    <= tout_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_bits_d  = n_bits_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        fill_d    = fill_q;
        match_d   = match_q;
        tout_d    = tout_q;
        locked_d  = locked_q;
        fail_d    = fail_q;
        p         = s_q[8] ^ s_q[4];
        s_rx      = {s_q[7:0], i_rx_bit};
        lock_now  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d   = ST_SEED;
                    n_bits_d  = i_n_bits;
                    s_d       = '0;
                    bit_cnt_d = '0;
                    err_cnt_d = '0;
                    fill_d    = '0;
                    match_d   = '0;
                    tout_d    = '0;
                    locked_d  = 1'b0;
                    fail_d    = 1'b0;
                end
            end
            ST_SEED: state_d = ST_SYNC;
            ST_SYNC: begin
                if (i_rx_valid) begin
                    tout_d = tout_q + 1'b1;
                    s_d    = s_rx;
                    if (fill_q < 4'd9) begin
                        // An all-zero window is the LFSR lockup state; refill instead of verifying.
                        fill_d = (fill_q == 4'd8 && s_rx == 9'd0) ? 4'd0 : fill_q + 4'd1;
                    end else if (i_rx_bit == p) begin
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 == LOCK_CNT) begin
                            lock_now = 1'b1;
                        end
                    end else begin
                        fill_d  = 4'd1;
                        match_d = '0;
                    end
                    if (lock_now) begin
                        state_d  = ST_COUNT;
                        locked_d = 1'b1;
                    end else if (tout_q + 1'b1 == TO_LAST) begin
                        state_d = ST_DONE;
                        fail_d  = 1'b1;
                    end
                end
            end
            ST_COUNT: begin
                if (n_bits_q == '0) begin
                    state_d = ST_DONE;
                end else if (i_rx_valid) begin
                    // Predictor free-runs so a corrupted rx bit costs exactly one error.
                    s_d       = {s_q[7:0], p};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (i_rx_bit != p && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (bit_cnt_q + CNT_W'(1) == n_bits_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_abort) begin
            state_d   = ST_IDLE;
            s_d       = '0;
            n_bits_d  = '0;
            bit_cnt_d = '0;
            err_cnt_d = '0;
            fill_d    = '0;
            match_d   = '0;
            tout_d    = '0;
            locked_d  = 1'b0;
            fail_d    = 1'b0;
        end
    end

    assign o_gen_rst_n = (state_q == ST_SYNC) || (state_q == ST_COUNT);
    assign o_busy      = (state_q == ST_SEED) || (state_q == ST_SYNC) || (state_q == ST_COUNT);
    assign o_locked    = (state_q == ST_COUNT) || ((state_q == ST_DONE) && locked_q);
    assign o_done      = (state_q == ST_DONE);
    assign o_lock_fail = (state_q == ST_DONE) && fail_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;
    assign o_state_dbg = state_q;

endmodule

// File: tb/tb_prbs9_ber_ctrl.sv
// Bench for prbs9_ber_ctrl: directed runs, expected results queued at start and
// checked by a monitor when o_done rises.
module tb_prbs9_ber_ctrl;

    localparam int CNT_W = 16;
    localparam int ERR_W = 4;

    typedef struct packed {
        logic [CNT_W-1:0] bits;
        logic [ERR_W-1:0] errs;
        logic             fail;
        logic             locked;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] n_bits;
    logic             rx_bit;
    logic             rx_valid;
    logic             gen_rst_n;
    logic             busy;
    logic             locked;
    logic             done;
    logic             lock_fail;
    logic [CNT_W-1:0] bit_count;
    logic [ERR_W-1:0] err_count;
    logic [2:0]       state_dbg;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [8:0] gen;
    int   sent;
    logic done_prev = 1'b0;

    prbs9_ber_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W), .LOCK_LEN(9), .TIMEOUT(1024)) dut (
        .clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort), .i_n_bits(n_bits),
        .i_rx_bit(rx_bit), .i_rx_valid(rx_valid), .o_gen_rst_n(gen_rst_n), .o_busy(busy),
        .o_locked(locked), .o_done(done), .o_lock_fail(lock_fail), .o_bit_count(bit_count),
        .o_err_count(err_count), .o_state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one queued result per completed run.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: o_done rose with no run expected");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bit_count", 32'(bit_count), 32'(e.bits));
                check("err_count", 32'(err_count), 32'(e.errs));
                check("lock_fail", 32'(lock_fail), 32'(e.fail));
                check("locked", 32'(locked), 32'(e.locked));
                check("gen_rst_n_done", 32'(gen_rst_n), 32'd0);
            end
        end
        done_prev = done;
    end

    task automatic check_idle(input string tag);
        check({tag, "_gen_rst_n"}, 32'(gen_rst_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_bit_count"}, 32'(bit_count), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        n_bits = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        rx_valid = 1'b0;
    endtask

    // mode: 0 clean, 1 three inverted bits, 2 gapped valid, 3 all zeros, 4 ones after lock
    task automatic run(input int n, input int mode, input logic push, input exp_t e,
                       input int abort_at);
        logic finished, aborted, v, b, toggle;
        logic [CNT_W-1:0] last_cnt;
        int frozen_checks;
        finished = 1'b0;
        aborted = 1'b0;
        toggle = 1'b1;
        frozen_checks = 0;
        last_cnt = '0;
        gen = 9'b110101010;
        sent = 0;
        if (push) exp_q.push_back(e);
        pulse_start(n);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (abort_at >= 0 && locked && bit_count == CNT_W'(abort_at)) begin
                abort = 1'b1;
                rx_valid = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                check_idle("abort");
                aborted = 1'b1;
                break;
            end
            if (mode == 2 && !rx_valid && locked && frozen_checks < 3) begin
                check("frozen_on_invalid", 32'(bit_count), 32'(last_cnt));
                frozen_checks++;
            end
            last_cnt = bit_count;
            v = (mode == 2) ? toggle : 1'b1;
            toggle = ~toggle;
            b = 1'b0;
            if (v) begin
                b = gen[8] ^ gen[4];
                gen = {gen[7:0], b};
                if (mode == 3) b = 1'b0;
                if (mode == 4 && locked) b = 1'b1;
                if (mode == 1 && (sent == 60 || sent == 100 || sent == 200)) b = ~b;
                sent++;
            end
            rx_bit = b;
            rx_valid = v;
        end
        rx_valid = 1'b0;
        if (!finished && !aborted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: mode %0d never reached DONE", mode);
        end
        if (mode == 3) check("timeout_valid_bits", 32'(sent), 32'd1024);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        n_bits = '0;
        rx_bit = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_lock_fail", 32'(lock_fail), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        e = '{bits: 16'd100, errs: 4'd0, fail: 1'b0, locked: 1'b1};
        run(100, 0, 1'b1, e, -1);
        e = '{bits: 16'd500, errs: 4'd3, fail: 1'b0, locked: 1'b1};
        run(500, 1, 1'b1, e, -1);
        e = '{bits: 16'd64, errs: 4'd0, fail: 1'b0, locked: 1'b1};
        run(64, 2, 1'b1, e, -1);
        e = '{bits: 16'd0, errs: 4'd0, fail: 1'b1, locked: 1'b0};
        run(100, 3, 1'b1, e, -1);
        e = '{bits: 16'd200, errs: 4'd15, fail: 1'b0, locked: 1'b1};
        run(200, 4, 1'b1, e, -1);
        e = '{bits: 16'd0, errs: 4'd0, fail: 1'b0, locked: 1'b1};
        run(0, 0, 1'b1, e, -1);
        e = '{bits: 16'd0, errs: 4'd0, fail: 1'b0, locked: 1'b0};
        run(100, 0, 1'b0, e, 40);

        // Asynchronous reset while still hunting for lock on a dead stream.
        pulse_start(100);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            rx_bit = 1'b0;
            rx_valid = 1'b1;
        end
        @(posedge clk); #1;
        check("sync_busy", 32'(busy), 32'd1);
        check("sync_gen_rst_n", 32'(gen_rst_n), 32'd1);
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        e = '{bits: 16'd100, errs: 4'd0, fail: 1'b0, locked: 1'b1};
        run(100, 0, 1'b1, e, -1);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_done: %0d expected results never reported", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
